// File: rtl/seq_add_pkg.sv
// Shared types and limits for the sequential chunked adder.
// Chunk width, legal NWORDS range and the control FSM state encoding.
package seq_add_pkg;

   localparam int unsigned CHUNK_W    = 16;
   localparam int unsigned NWORDS_MIN = 1;
   localparam int unsigned NWORDS_MAX = 8;
   // Wide enough to index NWORDS_MAX chunks.
   localparam int unsigned IDX_W      = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : seq_add_pkg

// File: rtl/seq_add64_cla16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with
// group generate/propagate feeding a second-level lookahead.
module cla16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] sum_o,
   output logic        co_o
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  pg;
   logic [4:0]  gc;

   always_comb begin
      g  = a_i & b_i;
      p  = a_i ^ b_i;
      gg = '0;
      pg = '0;
      gc = '0;
      c  = '0;

      // Group generate / propagate
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pg[k] = &p[4*k +: 4];
      end

      gc[0] = c_i;
      gc[1] = gg[0] | (pg[0] & c_i);
      gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_i);
      gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
            | (pg[2] & pg[1] & pg[0] & c_i);
      gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
            | (pg[3] & pg[2] & pg[1] & gg[0])
            | (pg[3] & pg[2] & pg[1] & pg[0] & c_i);

      // Bit carries inside each group from the group carry-in
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end

      sum_o = p ^ c;
      co_o  = gc[4];
   end

endmodule : cla16

// File: rtl/seq_add64.sv
// Sequential W-bit adder processing one 16-bit chunk per cycle through a
// single CLA. Define SEQ_ADD_SUB_EN to add the sub port (a - b).
module seq_add64
   import seq_add_pkg::*;
#(
   parameter  int unsigned NWORDS = 4,
   localparam int unsigned W      = CHUNK_W * NWORDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
`ifdef SEQ_ADD_SUB_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [W-1:0]       b_eff;
   logic               cin_eff;
   logic               accept;
   logic               last_chunk;
   logic [CHUNK_W-1:0] a_chunk;
   logic [CHUNK_W-1:0] b_chunk;
   logic [CHUNK_W-1:0] cla_sum;
   logic               cla_co;

   // Effective B operand and carry-in captured at accept
`ifdef SEQ_ADD_SUB_EN
   always_comb begin
      b_eff   = sub ? ~b : b;
      cin_eff = sub ? 1'b1 : cin;
   end
`else
   always_comb begin
      b_eff   = b;
      cin_eff = cin;
   end
`endif

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)     state_d = RUN;
         RUN:     if (last_chunk) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   assign accept     = in_valid && in_ready;
   assign last_chunk = (idx_q == IDX_W'(NWORDS - 1));

   // Chunk select for the shared adder
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < int'(NWORDS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_chunk = a_q[i*CHUNK_W +: CHUNK_W];
            b_chunk = b_q[i*CHUNK_W +: CHUNK_W];
         end
      end
   end

   cla16 u_cla16 (
      .a_i   (a_chunk),
      .b_i   (b_chunk),
      .c_i   (carry_q),
      .sum_o (cla_sum),
      .co_o  (cla_co)
   );

   // Datapath next-state: capture on accept, one chunk per RUN cycle
   always_comb begin
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      if (accept) begin
         a_d     = a;
         b_d     = b_eff;
         carry_d = cin_eff;
         idx_d   = '0;
      end

      if (state_q == RUN) begin
         for (int i = 0; i < int'(NWORDS); i++) begin
            if (idx_q == IDX_W'(i)) begin
               sum_d[i*CHUNK_W +: CHUNK_W] = cla_sum;
            end
         end
         carry_d = cla_co;
         idx_d   = last_chunk ? '0 : idx_q + IDX_W'(1);
         if (last_chunk) begin
            cout_d = cla_co;
            ovf_d  = (a_q[W-1] == b_q[W-1]) && (cla_sum[CHUNK_W-1] != a_q[W-1]);
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule : seq_add64

// File: tb/tb_seq_add64.sv
// Directed self-checking bench for seq_add64 (NWORDS=4); subtract
// scenarios run only when SEQ_ADD_SUB_EN is defined.
module tb_seq_add64;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef SEQ_ADD_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_add64 #(.NWORDS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SEQ_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Present one operand set for a single edge, then scramble the inputs.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
      a        = av;
      b        = bv;
      cin      = ci;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      cin      = 1'($urandom);
   endtask

   // Cycles from the accepting edge until out_valid; -1 if it never comes.
   task automatic wait_done(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (out_valid !== 1'b1) n = -1;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '1; b = '1; cin = 1'b1;
`ifdef SEQ_ADD_SUB_EN
      sub = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (sum !== 64'h0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
      checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
   endtask

   task automatic test_carry_chain();
      int n;
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      wait_done(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL wrap_latency: got %0d expected 4", n); end
      checks++; if (sum !== 64'h0) begin errors++; $display("FAIL wrap_sum: got %h expected 0", sum); end
      checks++; if ({cout, ovf} !== 2'b10) begin errors++; $display("FAIL wrap_cout_ovf: got %b expected 10", {cout, ovf}); end
      release_result();
      checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL wrap_release: in_ready,out_valid=%b expected 10", {in_ready, out_valid}); end

      start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
      wait_done(n);
      checks++; if (sum !== 64'h2222_2222_2222_2211) begin errors++; $display("FAIL mixed_sum: got %h expected 2222222222222211", sum); end
      checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL mixed_cout_ovf: got %b expected 00", {cout, ovf}); end
      release_result();

      start_op(64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1);
      wait_done(n);
      checks++; if (sum !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL cin_sum: got %h expected 0000000100000000", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL cin_cout: got %b expected 0", cout); end
      release_result();
   endtask

   task automatic test_overflow();
      int n;
      start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      wait_done(n);
      checks++; if (sum !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL posovf_sum: got %h expected 8000000000000000", sum); end
      checks++; if ({cout, ovf} !== 2'b01) begin errors++; $display("FAIL posovf_cout_ovf: got %b expected 01", {cout, ovf}); end
      release_result();

      start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      wait_done(n);
      checks++; if (sum !== 64'h0) begin errors++; $display("FAIL negovf_sum: got %h expected 0", sum); end
      checks++; if ({cout, ovf} !== 2'b11) begin errors++; $display("FAIL negovf_cout_ovf: got %b expected 11", {cout, ovf}); end
      release_result();
   endtask

   task automatic test_backpressure();
      int n;
      start_op(64'h0001_0000_0000_0005, 64'h0002_0000_0000_0006, 1'b0);
      wait_done(n);
      // Offer a new operand while DONE; it must not be taken.
      a = 64'hDEAD; b = 64'hBEEF; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL hold_flags%0d: out_valid,in_ready=%b expected 10", i, {out_valid, in_ready}); end
         checks++; if (sum !== 64'h0003_0000_0000_000B) begin errors++; $display("FAIL hold_sum%0d: got %h expected 000300000000000b", i, sum); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL hold_release: in_ready,out_valid=%b expected 10", {in_ready, out_valid}); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL no_accept_in_done: in_ready=%b expected 1", in_ready); end
      checks++; if (sum !== 64'h0003_0000_0000_000B) begin errors++; $display("FAIL idle_keeps_sum: got %h expected 000300000000000b", sum); end
   endtask

   task automatic test_reset_in_run();
      int n;
      int seen;
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (sum !== 64'h0) begin errors++; $display("FAIL rstrun_sum: got %h expected 0", sum); end
      checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL rstrun_flags: in_ready,out_valid=%b expected 10", {in_ready, out_valid}); end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rstrun_no_result: out_valid seen %0d times expected 0", seen); end
      start_op(64'd3, 64'd4, 1'b0);
      wait_done(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL after_rst_latency: got %0d expected 4", n); end
      checks++; if (sum !== 64'd7) begin errors++; $display("FAIL after_rst_sum: got %h expected 7", sum); end
      release_result();
   endtask

   task automatic test_back_to_back();
      int n;
      start_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
      wait_done(n);
      checks++; if (sum !== 64'h0001_0000_0001_0000) begin errors++; $display("FAIL b2b_first: got %h expected 0001000000010000", sum); end
      release_result();
      start_op(64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b1);
      wait_done(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", n); end
      checks++; if ({sum, cout} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0}) begin errors++; $display("FAIL b2b_second: sum=%h cout=%b expected ffffffffffffffff 0", sum, cout); end
      release_result();
   endtask

`ifdef SEQ_ADD_SUB_EN
   task automatic test_subtract();
      int n;
      sub = 1'b1;
      start_op(64'd5, 64'd7, 1'b1);
      sub = 1'b0;
      wait_done(n);
      checks++; if (sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_neg_sum: got %h expected fffffffffffffffe", sum); end
      checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL sub_neg_cout_ovf: got %b expected 00", {cout, ovf}); end
      release_result();
      sub = 1'b1;
      start_op(64'd7, 64'd5, 1'b0);
      sub = 1'b0;
      wait_done(n);
      checks++; if (sum !== 64'd2) begin errors++; $display("FAIL sub_pos_sum: got %h expected 2", sum); end
      checks++; if ({cout, ovf} !== 2'b10) begin errors++; $display("FAIL sub_pos_cout_ovf: got %b expected 10", {cout, ovf}); end
      release_result();
   endtask
`endif

   initial begin
      test_reset();
      test_carry_chain();
      test_overflow();
      test_backpressure();
      test_reset_in_run();
      test_back_to_back();
`ifdef SEQ_ADD_SUB_EN
      test_subtract();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_seq_add64
